// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter in front of an async FIFO write port.
// A winner is picked in IDLE, then owns the write port until its last beat is accepted.
module fifo_wr_arbiter #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [15:0]           wcount
);

    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   g_idx;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            win_found;
    logic            accept;
    int              sum;
    logic [DSIZE-1:0] data_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*DSIZE +: DSIZE];
        end
    end

    // Walk offsets from the far end so the candidate nearest rr_ptr wins last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        sum       = 0;
        cand      = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            sum = int'(rr_ptr) + off;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = IW'(sum);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            g_idx  <= '0;
            gnt    <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state <= BUSY;
                        g_idx <= win_idx;
                        gnt   <= ONE_HOT0 << win_idx;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && req_last[g_idx]) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= (g_idx == LAST_IDX) ? '0 : g_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wcount <= '0;
        end else if (winc) begin
            wcount <= wcount + 16'd1;
        end
    end

    // The write path is combinational so a beat lands in the FIFO the cycle it is offered.
    assign accept    = (state == BUSY) && req_valid[g_idx] && !wfull;
    assign winc      = accept;
    assign req_ready = accept ? gnt : '0;
    assign wdata     = (state == BUSY) ? data_arr[g_idx] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter, checked against a packet-ownership model.
module tb_fifo_wr_arbiter;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [15:0]           wcount;

    fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt       (gnt),
        .busy      (busy),
        .wcount    (wcount)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;

    // Model: who owns the write port, where the next search starts, how many writes so far.
    int          m_busy;
    int          m_owner;
    int          m_ptr;
    logic [15:0] m_count;

    int          rem [NREQ];
    logic [7:0]  seq [NREQ];
    bit          reload;
    bit          log_en;
    logic [7:0]  wr_log [$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_count = '0;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                 input logic f, output logic acc, output int who);
        logic [3:0] e_gnt;
        logic [3:0] e_ready;
        logic [7:0] e_wdata;
        bit         found;
        int         idx;
        req_valid = v;
        req_last  = l;
        req_data  = d;
        wfull     = f;
        #1;
        e_gnt   = '0;
        e_ready = '0;
        e_wdata = '0;
        acc     = 1'b0;
        who     = m_owner;
        if (m_busy != 0) begin
            e_gnt   = 4'b0001 << m_owner;
            e_wdata = d[m_owner*8 +: 8];
            acc     = v[m_owner] && !f;
            if (acc) e_ready = e_gnt;
        end
        checkOutput("gnt", 32'(gnt), 32'(e_gnt));
        checkOutput("busy", 32'(busy), 32'(m_busy != 0));
        checkOutput("winc", 32'(winc), 32'(acc));
        checkOutput("wdata", 32'(wdata), 32'(e_wdata));
        checkOutput("req_ready", 32'(req_ready), 32'(e_ready));
        checkOutput("wcount", 32'(wcount), 32'(m_count));
        checkOutput("no_overflow", 32'(winc & wfull), 32'd0);
        checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        checkOutput("ready_in_gnt", 32'(req_ready & ~gnt), 32'd0);
        if (log_en && winc) wr_log.push_back(wdata);
        if (m_busy != 0) begin
            if (acc) begin
                m_count++;
                if (l[m_owner]) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % NREQ;
                end
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && v[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_busy  = 1;
                end
            end
        end
        @(negedge wclk);
    endtask

    task automatic driveCycle(input logic [3:0] vmask, input logic f);
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        acc;
        int          who;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            v[i]       = vmask[i] && (rem[i] > 0);
            l[i]       = (rem[i] == 1);
            d[i*8 +: 8] = seq[i];
        end
        applyStimulus(v, l, d, f, acc, who);
        if (acc) begin
            rem[who]--;
            seq[who]++;
            if (rem[who] == 0 && reload) rem[who] = int'($urandom_range(1, 4));
        end
    endtask

    task automatic doReset();
        wrst      = 1'b1;
        req_valid = '1;
        req_last  = '0;
        req_data  = $urandom;
        wfull     = 1'b0;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_winc", 32'(winc), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_wdata", 32'(wdata), 32'd0);
        checkOutput("rst_wcount", 32'(wcount), 32'd0);
        modelReset();
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    initial begin
        logic [3:0]  order [$];
        logic [3:0]  prev;
        logic [15:0] wrap_exp [3];
        logic [3:0]  vm;
        wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001};
        wrst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
        reload = 1'b0; log_en = 1'b0;
        for (int i = 0; i < NREQ; i++) begin rem[i] = 0; seq[i] = '0; end
        doReset();

        // All four requesters streaming 2-beat packets.
        for (int i = 0; i < NREQ; i++) begin rem[i] = 2; seq[i] = 8'(i * 16); end
        prev = '0;
        for (int c = 0; c < 16; c++) begin
            if (gnt != 4'b0000 && gnt != prev && order.size() < 5) begin
                order.push_back(gnt);
                if (order.size() == 5) checkOutput("rr_wcount8", 32'(wcount), 32'd8);
            end
            prev = gnt;
            for (int i = 0; i < NREQ; i++) if (rem[i] == 0) rem[i] = 2;
            driveCycle(4'b1111, 1'b0);
        end
        checkOutput("rr_grants", 32'(order.size()), 32'd5);
        for (int k = 0; k < order.size(); k++) checkOutput("rr_order", 32'(order[k]), 32'(4'b0001 << (k % 4)));

        // Requester 2, 5-beat packet stalled by wfull for 3 cycles.
        doReset();
        rem[2] = 5; seq[2] = 8'h20;
        wr_log.delete(); log_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c >= 2 && c <= 4) checkOutput("stall_gnt", 32'(gnt), 32'(4'b0100));
            driveCycle(4'b0100, (c >= 2 && c <= 4));
        end
        log_en = 1'b0;
        checkOutput("stall_wcount", 32'(wcount), 32'd5);
        checkOutput("stall_beats", 32'(wr_log.size()), 32'd5);
        for (int k = 0; k < wr_log.size(); k++) checkOutput("stall_order", 32'(wr_log[k]), 32'(8'h20 + k));

        // Requester 1 drops valid mid-packet while requester 0 waits.
        doReset();
        rem[1] = 3; seq[1] = 8'h10; rem[0] = 2; seq[0] = 8'h00;
        for (int c = 0; c < 11; c++) begin
            vm = (c < 2) ? 4'b0010 : (c < 6) ? 4'b0001 : 4'b0011;
            if (c >= 2 && c <= 5) checkOutput("gap_gnt", 32'(gnt), 32'(4'b0010));
            if (c == 9) checkOutput("gap_then_r0", 32'(gnt), 32'(4'b0001));
            driveCycle(vm, 1'b0);
        end

        // Write counter wrap.
        doReset();
        rem[0] = 70000;
        for (int c = 0; c < 70000 && m_count != 16'hFFFE; c++) driveCycle(4'b0001, 1'b0);
        checkOutput("preload", 32'(wcount), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            driveCycle(4'b0001, 1'b0);
            checkOutput("wrap", 32'(wcount), 32'(wrap_exp[k]));
        end

        // Single-beat packet, then reset during beat 3 of a 6-beat packet.
        doReset();
        rem[2] = 1; rem[3] = 6; rem[1] = 2;
        driveCycle(4'b0100, 1'b0);
        driveCycle(4'b0100, 1'b0);
        checkOutput("single_beat_done", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) driveCycle(4'b1000, 1'b0);
        req_valid = 4'b1010; req_last = '0; req_data = 32'hA5A5A5A5; wfull = 1'b0;
        #2 wrst = 1'b1;
        #1;
        checkOutput("abort_gnt", 32'(gnt), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_winc", 32'(winc), 32'd0);
        checkOutput("abort_ready", 32'(req_ready), 32'd0);
        checkOutput("abort_wdata", 32'(wdata), 32'd0);
        checkOutput("abort_wcount", 32'(wcount), 32'd0);
        modelReset();
        @(negedge wclk);
        wrst = 1'b0;
        rem[3] = 2; rem[1] = 2;
        driveCycle(4'b1010, 1'b0);
        checkOutput("post_abort_gnt", 32'(gnt), 32'(4'b0010));
        for (int c = 0; c < 6; c++) driveCycle(4'b1010, 1'b0);

        // Random traffic with random packet lengths and random backpressure.
        doReset();
        reload = 1'b1;
        for (int i = 0; i < NREQ; i++) rem[i] = int'($urandom_range(1, 4));
        for (int c = 0; c < 3000; c++) driveCycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
